// File: rtl/imem_loader.sv
// imem_loader: receives a program image as a valid/ready byte stream and writes it into
// a 64x32 instruction RAM. Bytes are packed little-endian into words. The CPU is held in
// reset until the whole image has been written.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   start     one-cycle pulse, begins a load from IDLE or DONE
//   in_valid  byte stream valid
//   in_data   byte stream data
//   in_ready  byte accepted this cycle when in_valid is also high
//   we        one-cycle RAM write strobe per assembled word
//   waddr     RAM word address, holds its value between strobes
//   wdata     RAM write data, holds its value between strobes
//   busy      a load is in progress
//   done      the image has been written; held until the next start
//   err       the header word count was out of range; sticky until the next start
//   cpu_hold  keeps the processor in reset while high
module imem_loader #(
    parameter int unsigned N      = 32,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [N-1:0]      wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    // One extra bit so a count of DEPTH words fits without wrapping.
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_BYTES,
        S_WRITE,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   total_q, total_d;
    logic [N-1:0]       word_q, word_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [N-1:0]       wdata_q, wdata_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               xfer_c;

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            total_q    <= '0;
            word_q     <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            total_q    <= total_d;
            word_q     <= word_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cpu_hold_q <= cpu_hold_d;
        end
    end

    // in_ready_q always reflects the current state, so it gates transfers directly.
    assign xfer_c = in_valid & in_ready_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        word_d  = word_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_COUNT;
                    err_d   = 1'b0;
                end
            end
            S_COUNT: begin
                if (xfer_c) begin
                    if (in_data > 8'(DEPTH)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // A header of zero stands for a full memory image.
                        total_d = (in_data == 8'd0) ? CNT_W'(DEPTH) : CNT_W'(in_data);
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = S_BYTES;
                    end
                end
            end
            S_BYTES: begin
                if (xfer_c) begin
                    word_d[{idx_q, 3'b000} +: 8] = in_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        // Strobe is launched here so it is registered during WRITE.
                        we_d    = 1'b1;
                        waddr_d = cnt_q[ADDR_W-1:0];
                        wdata_d = word_d;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                cnt_d   = cnt_q + CNT_W'(1);
                idx_d   = '0;
                state_d = ((cnt_q + CNT_W'(1)) == total_q) ? S_DONE : S_BYTES;
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs follow the state being entered.
        in_ready_d = (state_d == S_COUNT) || (state_d == S_BYTES);
        busy_d     = (state_d == S_COUNT) || (state_d == S_BYTES) || (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        cpu_hold_d = (state_d != S_DONE);
    end

    assign in_ready = in_ready_q;
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign cpu_hold = cpu_hold_q;

endmodule
